// File: rtl/button_debounce.sv
// button_debounce: synchronises and debounces N_BTN raw active-low push buttons.
// Each channel has a 2-FF synchroniser followed by a four-state debounce FSM.
// The FSM emits one-cycle press, release and long-hold pulses plus a held level.
// A shared 6-bit counter tallies accepted presses across all channels, mod 64.
module button_debounce #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int LONG_CYCLES     = 13500000,
    parameter int CNT_W           = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] pressed,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output logic [5:0]       event_count
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // Terminal counter values, pre-sized to the counter width.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_PRE  = CNT_W'(LONG_CYCLES - 2);

    // Press pulses about to be registered, used so event_count moves with press_pulse.
    logic [N_BTN-1:0] press_pulse_next;
    logic [5:0]       press_inc;
    logic [5:0]       event_count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_ch
            logic             sync1_reg;
            logic             sync2_reg;
            logic             s;
            state_t           state_reg;
            state_t           state_next;
            logic [CNT_W-1:0] dcnt_reg;
            logic [CNT_W-1:0] dcnt_next;
            logic [CNT_W-1:0] hcnt_reg;
            logic [CNT_W-1:0] hcnt_next;
            logic             long_flag_reg;
            logic             long_flag_next;
            logic             press_next;
            logic             release_next;
            logic             long_next;
            logic             press_reg;
            logic             release_reg;
            logic             long_reg;

            // Two-stage synchroniser; preset to 1 so reset looks like "released".
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                end else begin
                    sync1_reg <= btn_n[gi];
                    sync2_reg <= sync1_reg;
                end
            end

            assign s = sync2_reg;

            // FSM state, counters and registered output pulses.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg     <= IDLE;
                    dcnt_reg      <= '0;
                    hcnt_reg      <= '0;
                    long_flag_reg <= 1'b0;
                    press_reg     <= 1'b0;
                    release_reg   <= 1'b0;
                    long_reg      <= 1'b0;
                end else begin
                    state_reg     <= state_next;
                    dcnt_reg      <= dcnt_next;
                    hcnt_reg      <= hcnt_next;
                    long_flag_reg <= long_flag_next;
                    press_reg     <= press_next;
                    release_reg   <= release_next;
                    long_reg      <= long_next;
                end
            end

            // Next-state logic: debounce both edges, time the hold while pressed.
            always_comb begin
                state_next     = state_reg;
                dcnt_next      = dcnt_reg;
                hcnt_next      = hcnt_reg;
                long_flag_next = long_flag_reg;
                press_next     = 1'b0;
                release_next   = 1'b0;
                long_next      = 1'b0;
                case (state_reg)
                    IDLE: begin
                        if (!s) begin
                            state_next = PRESS_WAIT;
                            dcnt_next  = '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (s) begin
                            state_next = IDLE;
                        end else if (dcnt_reg == DEB_LAST) begin
                            state_next     = HELD;
                            press_next     = 1'b1;
                            hcnt_next      = '0;
                            long_flag_next = 1'b0;
                        end else begin
                            dcnt_next = dcnt_reg + CNT_W'(1);
                        end
                    end
                    HELD, RELEASE_WAIT: begin
                        // Hold timer runs in both pressed states so a bouncy
                        // release does not delay or suppress the long pulse.
                        if (hcnt_reg != LONG_LAST) begin
                            hcnt_next = hcnt_reg + CNT_W'(1);
                            if ((hcnt_reg == LONG_PRE) && !long_flag_reg) begin
                                long_next      = 1'b1;
                                long_flag_next = 1'b1;
                            end
                        end
                        if (state_reg == HELD) begin
                            if (s) begin
                                state_next = RELEASE_WAIT;
                                dcnt_next  = '0;
                            end
                        end else begin
                            if (!s) begin
                                state_next = HELD;
                            end else if (dcnt_reg == DEB_LAST) begin
                                state_next   = IDLE;
                                release_next = 1'b1;
                            end else begin
                                dcnt_next = dcnt_reg + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_next = IDLE;
                    end
                endcase
            end

            assign press_pulse_next[gi] = press_next;
            assign press_pulse[gi]      = press_reg;
            assign release_pulse[gi]    = release_reg;
            assign long_pulse[gi]       = long_reg;
            assign pressed[gi]          = (state_reg == HELD) || (state_reg == RELEASE_WAIT);
        end
    endgenerate

    // Number of channels accepting a press this cycle.
    always_comb begin
        press_inc = '0;
        for (int i = 0; i < N_BTN; i++) begin
            press_inc = press_inc + {5'b0, press_pulse_next[i]};
        end
    end

    // Press tally, updated on the same edge that raises press_pulse; wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_count_reg <= '0;
        end else begin
            event_count_reg <= event_count_reg + press_inc;
        end
    end

    assign event_count = event_count_reg;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce with short debounce/long-hold timings.
// Stimulus tasks push the expected pulses (cycle, kind, channel, count) into a
// queue; a monitor pops and compares whenever the DUT shows a pulse.
module tb_button_debounce;

    localparam int N_BTN = 2;
    localparam int DEB   = 4;
    localparam int LONG  = 10;

    logic             clk;
    logic             rst_n;
    logic [N_BTN-1:0] btn_n;
    logic [N_BTN-1:0] pressed;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] release_pulse;
    logic [N_BTN-1:0] long_pulse;
    logic [5:0]       event_count;

    button_debounce #(
        .N_BTN          (N_BTN),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG),
        .CNT_W          (24)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_n        (btn_n),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .event_count  (event_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count of rising clock edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         kind;   // 0 press, 1 release, 2 long
        int         ch;
        logic [5:0] cnt;
    } ev_t;

    ev_t        exp_q[$];
    int         total = 0;
    int         bad = 0;
    logic [5:0] exp_cnt = '0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_ev(input int c, input int kind, input int ch, input logic [5:0] cnt);
        ev_t e;
        e.cyc  = c;
        e.kind = kind;
        e.ch   = ch;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    function automatic logic get_pulse(input int kind, input int ch);
        case (kind)
            0:       return press_pulse[ch];
            1:       return release_pulse[ch];
            default: return long_pulse[ch];
        endcase
    endfunction

    // Monitor: runs just after every rising edge and matches pulses against the queue.
    task automatic monitor_loop();
        ev_t e;
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                total++;
                bad++;
                $display("FAIL missed_event: kind=%0d ch=%0d got no pulse by cycle %0d expected at cycle %0d",
                         e.kind, e.ch, cyc, e.cyc);
            end
            for (int k = 0; k < 3; k++) begin
                for (int ch = 0; ch < N_BTN; ch++) begin
                    if (get_pulse(k, ch)) begin
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL unexpected_pulse: kind=%0d ch=%0d at cycle %0d, expected none",
                                     k, ch, cyc);
                        end else begin
                            e = exp_q.pop_front();
                            if (e.cyc != cyc || e.kind != k || e.ch != ch ||
                                event_count != e.cnt || pressed[ch] != (k != 1)) begin
                                bad++;
                                $display("FAIL event_match: got cyc=%0d kind=%0d ch=%0d cnt=%0d pressed=%0d expected cyc=%0d kind=%0d ch=%0d cnt=%0d pressed=%0d",
                                         cyc, k, ch, event_count, pressed[ch],
                                         e.cyc, e.kind, e.ch, e.cnt, (e.kind != 1));
                            end else begin
                                $display("event cyc=%0d kind=%0d ch=%0d cnt=%0d ok", cyc, k, ch, event_count);
                            end
                        end
                    end
                end
            end
        end
    endtask

    // Clean press on every channel in mask, held for hold cycles, then released.
    task automatic press_seq(input logic [1:0] mask, input int hold);
        int c;
        @(negedge clk);
        c = cyc;
        btn_n = btn_n & ~mask;
        exp_cnt = exp_cnt + 6'(int'(mask[0]) + int'(mask[1]));
        for (int ch = 0; ch < N_BTN; ch++) if (mask[ch]) push_ev(c + 7, 0, ch, exp_cnt);
        if (hold >= 12)
            for (int ch = 0; ch < N_BTN; ch++) if (mask[ch]) push_ev(c + 16, 2, ch, exp_cnt);
        for (int ch = 0; ch < N_BTN; ch++) if (mask[ch]) push_ev(c + hold + 7, 1, ch, exp_cnt);
        repeat (hold) @(negedge clk);
        btn_n = btn_n | mask;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int         c;
        logic [1:0] m;
        logic [5:0] prev;
        bit         wrapped;

        rst_n = 1'b0;
        btn_n = 2'b11;
        fork
            monitor_loop();
        join_none

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_pressed", pressed, 0);
        check("reset_pulses", {press_pulse, release_pulse, long_pulse}, 0);
        check("reset_count", event_count, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Clean press on ch0.
        press_seq(2'b01, 8);
        check("clean_press_count", event_count, 1);

        // Bounce shorter than the debounce window.
        @(negedge clk);
        btn_n[0] = 1'b0;
        repeat (3) @(negedge clk);
        btn_n[0] = 1'b1;
        repeat (10) @(negedge clk);
        check("bounce_pressed", pressed, 0);
        check("bounce_count", event_count, exp_cnt);

        // Long hold on ch1.
        press_seq(2'b10, 20);

        // Release bounce on ch0 while held.
        @(negedge clk);
        c = cyc;
        btn_n[0] = 1'b0;
        exp_cnt = exp_cnt + 6'd1;
        push_ev(c + 7, 0, 0, exp_cnt);
        push_ev(c + 16, 2, 0, exp_cnt);
        push_ev(c + 37, 1, 0, exp_cnt);
        repeat (12) @(negedge clk);
        btn_n[0] = 1'b1;
        repeat (2) @(negedge clk);
        btn_n[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("release_bounce_pressed", pressed[0], 1);
        repeat (12) @(negedge clk);
        btn_n[0] = 1'b1;
        repeat (10) @(negedge clk);

        // Simultaneous press on both channels.
        press_seq(2'b11, 8);
        check("simul_count", event_count, exp_cnt);

        // Reset while ch0 is held, button stays low through reset release.
        @(negedge clk);
        c = cyc;
        btn_n[0] = 1'b0;
        exp_cnt = exp_cnt + 6'd1;
        push_ev(c + 7, 0, 0, exp_cnt);
        repeat (12) @(negedge clk);
        check("pre_reset_pressed", pressed[0], 1);
        rst_n = 1'b0;
        #1;
        check("midreset_pressed", pressed, 0);
        check("midreset_pulses", {press_pulse, release_pulse, long_pulse}, 0);
        check("midreset_count", event_count, 0);
        exp_cnt = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        c = cyc;
        exp_cnt = exp_cnt + 6'd1;
        push_ev(c + 7, 0, 0, exp_cnt);
        push_ev(c + 15, 1, 0, exp_cnt);
        repeat (8) @(negedge clk);
        btn_n[0] = 1'b1;
        repeat (10) @(negedge clk);
        check("after_reset_count", event_count, 1);

        // Keep pressing until the tally wraps past 63.
        wrapped = 1'b0;
        for (int i = 0; i < 40 && !wrapped; i++) begin
            m = (exp_cnt == 6'd63) ? 2'b01 : 2'b11;
            prev = exp_cnt;
            press_seq(m, 8);
            if (exp_cnt < prev) wrapped = 1'b1;
        end
        check("wrap_count", event_count, 0);

        repeat (20) @(negedge clk);
        check("leftover_events", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
